radiant_coinc_trig: RTL and testbench



---
 rtl/radiant_trig_pkg.sv | 22 ++
 rtl/radiant_coinc_trig_if.sv | 29 ++
 rtl/radiant_coinc_trig_oneshot.sv | 38 +++
 rtl/radiant_coinc_trig.sv | 120 ++++++++++++
 tb/tb_radiant_coinc_trig.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/radiant_trig_pkg.sv
// rtl/radiant_trig_pkg.sv - shared types, constants and window-length helper for the coincidence trigger
// Contents: state_t FSM encoding, WINDOW_OFFSET, WINLEN_W, win_len().
package radiant_trig_pkg;

  typedef enum logic [1:0] {
    DIS   = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2,
    CLR   = 2'd3
  } state_t;

  localparam int WINDOW_OFFSET = 7;
  localparam int WINLEN_W      = 8;

  // Four 5-bit fields plus a fixed offset; max 4*31+7 = 131 fits in 8 bits.
  function automatic logic [WINLEN_W-1:0] win_len(input logic [19:0] window);
    return WINLEN_W'(window[4:0]) + WINLEN_W'(window[9:5]) +
           WINLEN_W'(window[14:10]) + WINLEN_W'(window[19:15]) +
           WINLEN_W'(WINDOW_OFFSET);
  endfunction

endpackage

// File: rtl/radiant_coinc_trig_if.sv
// rtl/radiant_coinc_trig_if.sv - channel/config/result bundle for one coincidence trigger
// Signals: trig_i, en_i, maskb_i, window_i, thresh_i (to trigger); trig_o, active_cnt_o, trig_count_o (from trigger).
// Modports: master (drives inputs, observes results), slave (the trigger itself).
interface radiant_coinc_trig_if #(
  parameter int NUM_CH        = 24,
  parameter int ONESHOT_WIDTH = 20,
  parameter int THRESH_WIDTH  = 5
);
  localparam int CNT_W = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0]        trig_i;
  logic                     en_i;
  logic [NUM_CH-1:0]        maskb_i;
  logic [ONESHOT_WIDTH-1:0] window_i;
  logic [THRESH_WIDTH-1:0]  thresh_i;
  logic                     trig_o;
  logic [CNT_W-1:0]         active_cnt_o;
  logic [15:0]              trig_count_o;

  modport master (
    output trig_i, en_i, maskb_i, window_i, thresh_i,
    input  trig_o, active_cnt_o, trig_count_o
  );

  modport slave (
    input  trig_i, en_i, maskb_i, window_i, thresh_i,
    output trig_o, active_cnt_o, trig_count_o
  );
endinterface

// File: rtl/radiant_coinc_trig_oneshot.sv
// rtl/radiant_coinc_trig_oneshot.sv - per-channel rising-edge detect and retriggerable window oneshot
// Ports: clk, rst (async high), trig (discriminator level), mask (channel included),
//        clr (force counter to 0), len (window length), active (counter nonzero).
module trig_oneshot
  import radiant_trig_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                trig,
  input  logic                mask,
  input  logic                clr,
  input  logic [WINLEN_W-1:0] len,
  output logic                active
);
  logic                trig_d;
  logic [WINLEN_W-1:0] cnt;
  logic                rise;

  assign rise   = trig & ~trig_d & mask;
  assign active = (cnt != '0);

  // Clear beats a rise so a disabled trigger never holds an open window;
  // a rise beats the decrement so a retrigger reloads the full length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_d <= 1'b0;
      cnt    <= '0;
    end else begin
      trig_d <= trig;
      if (clr)
        cnt <= '0;
      else if (rise)
        cnt <= len;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/radiant_coinc_trig.sv
// rtl/radiant_coinc_trig.sv - programmable N-of-M coincidence trigger with holdoff and saturating count
// Ports: clk_i, rst_i (async high), bus (slave): trig_i, en_i, maskb_i, window_i, thresh_i in;
//        trig_o one-cycle pulse, active_cnt_o registered active-channel count, trig_count_o saturating count out.
module radiant_coinc_trig
  import radiant_trig_pkg::*;
#(
  parameter int NUM_CH        = 24,
  parameter int ONESHOT_WIDTH = 20,
  parameter int THRESH_WIDTH  = 5,
  parameter int HOLDOFF       = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  radiant_coinc_trig_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int CMP_W = (CNT_W > THRESH_WIDTH) ? CNT_W : THRESH_WIDTH;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

  state_t                   state_q, state_d;
  logic                     en_q;
  logic [NUM_CH-1:0]        maskb_q;
  logic [THRESH_WIDTH-1:0]  thresh_q;
  logic [WINLEN_W-1:0]      winlen_q;
  logic [ONESHOT_WIDTH-1:0] window_cfg;
  logic [NUM_CH-1:0]        active;
  logic [CNT_W-1:0]         pop;
  logic [CNT_W-1:0]         active_cnt_q;
  logic [7:0]               hold_cnt;
  logic                     trig_q;
  logic [15:0]              trig_count_q;
  logic                     capture;
  logic                     os_clr;
  logic                     cond;
  logic                     fire;

  assign window_cfg = bus.window_i;
  assign capture    = bus.en_i & ~en_q;
  assign os_clr     = ~bus.en_i | (state_q == DIS);
  assign cond       = (thresh_q != '0) && (CMP_W'(active_cnt_q) >= CMP_W'(thresh_q));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    trig_oneshot u_oneshot (
      .clk    (clk_i),
      .rst    (rst_i),
      .trig   (bus.trig_i[c]),
      .mask   (maskb_q[c]),
      .clr    (os_clr),
      .len    (winlen_q),
      .active (active[c])
    );
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < NUM_CH; c++)
      pop = pop + CNT_W'(active[c] & maskb_q[c]);
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= DIS;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (!bus.en_i) begin
      state_d = DIS;
    end else begin
      case (state_q)
        DIS:     state_d = ARMED;
        ARMED:   if (cond) state_d = HOLD;
        HOLD:    if (hold_cnt == '0) state_d = cond ? CLR : ARMED;
        CLR:     if (!cond) state_d = ARMED;
        default: state_d = DIS;
      endcase
    end
  end

  // FSM outputs; a coincidence on the same cycle enable drops is suppressed
  always_comb begin
    fire = (state_q == ARMED) && cond && bus.en_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q         <= 1'b0;
      maskb_q      <= '0;
      thresh_q     <= '0;
      winlen_q     <= '0;
      active_cnt_q <= '0;
      hold_cnt     <= '0;
      trig_q       <= 1'b0;
      trig_count_q <= '0;
    end else begin
      en_q   <= bus.en_i;
      trig_q <= fire;
      if (capture) begin
        maskb_q  <= bus.maskb_i;
        thresh_q <= bus.thresh_i;
        winlen_q <= win_len(window_cfg);
      end
      active_cnt_q <= bus.en_i ? pop : '0;
      if (fire)
        hold_cnt <= HOLD_LOAD;
      else if (state_q == HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
      if (capture)
        trig_count_q <= '0;
      else if (fire && trig_count_q != 16'hFFFF)
        trig_count_q <= trig_count_q + 1'b1;
    end
  end

  assign bus.trig_o       = trig_q;
  assign bus.active_cnt_o = active_cnt_q;
  assign bus.trig_count_o = trig_count_q;
endmodule

// File: tb/tb_radiant_coinc_trig.sv
// tb/tb_radiant_coinc_trig.sv - self-checking bench for radiant_coinc_trig
module tb_radiant_coinc_trig;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   mon_e;
  int   exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  radiant_coinc_trig_if #(.NUM_CH(24), .ONESHOT_WIDTH(20), .THRESH_WIDTH(5)) bus ();

  radiant_coinc_trig #(
    .NUM_CH(24), .ONESHOT_WIDTH(20), .THRESH_WIDTH(5), .HOLDOFF(16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Scoreboard: every trig_o pulse must match the next expected cycle.
  always @(negedge clk) begin
    if (bus.trig_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL trig_unexpected: trig_o high at cycle %0d, required low", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc !== mon_e) begin
          errors++;
          $display("FAIL trig_cycle: trig_o at cycle %0d, required cycle %0d", cyc, mon_e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [23:0] chans);
    bus.trig_i = chans;
    tick(1);
    bus.trig_i = '0;
  endtask

  task automatic enable_cfg(input logic [23:0] m, input logic [4:0] t, input logic [19:0] w);
    bus.en_i = 1'b0;
    tick(1);
    bus.maskb_i  = m;
    bus.thresh_i = t;
    bus.window_i = w;
    bus.en_i     = 1'b1;
    tick(1);
  endtask

  task automatic test_reset;
    bus.trig_i = '0; bus.en_i = 1'b0; bus.maskb_i = '0; bus.window_i = '0; bus.thresh_i = '0;
    rst = 1'b1;
    tick(2);
    checks++; if (bus.trig_o !== 1'b0) begin errors++; $display("FAIL reset_trig: got %0b required 0", bus.trig_o); end
    checks++; if (bus.active_cnt_o !== 5'd0) begin errors++; $display("FAIL reset_active: got %0d required 0", bus.active_cnt_o); end
    checks++; if (bus.trig_count_o !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", bus.trig_count_o); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_window_latency;
    int n;
    enable_cfg(24'h3, 5'd2, 20'h0);
    n = cyc;
    pulse(24'h1);
    tick(5);
    exp_q.push_back(n + 9);
    pulse(24'h2);
    tick(30);
    checks++; if (bus.trig_count_o !== 16'd1) begin errors++; $display("FAIL window_in_count: got %0d required 1", bus.trig_count_o); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL window_in_missed: %0d pending required 0", exp_q.size()); exp_q.delete(); end
    n = cyc;
    pulse(24'h1);
    tick(6);
    pulse(24'h2);
    tick(30);
    checks++; if (bus.trig_count_o !== 16'd1) begin errors++; $display("FAIL window_out_count: got %0d required 1", bus.trig_count_o); end
  endtask

  task automatic test_mask;
    int n;
    enable_cfg(24'h1, 5'd2, 20'h0);
    checks++; if (bus.trig_count_o !== 16'd0) begin errors++; $display("FAIL enable_clears_count: got %0d required 0", bus.trig_count_o); end
    n = cyc;
    pulse(24'h3);
    tick(1);
    checks++; if (bus.active_cnt_o !== 5'd1) begin errors++; $display("FAIL mask_active: got %0d required 1", bus.active_cnt_o); end
    tick(20);
    checks++; if (bus.trig_count_o !== 16'd0) begin errors++; $display("FAIL mask_count: got %0d required 0", bus.trig_count_o); end
    enable_cfg(24'h3, 5'd2, 20'h0);
    n = cyc;
    exp_q.push_back(n + 3);
    pulse(24'h3);
    tick(2);
    checks++; if (bus.trig_o !== 1'b1) begin errors++; $display("FAIL mask_latency: trig_o %0b at n+3 required 1", bus.trig_o); end
    tick(25);
    checks++; if (bus.trig_count_o !== 16'd1) begin errors++; $display("FAIL unmask_count: got %0d required 1", bus.trig_count_o); end
  endtask

  task automatic test_holdoff;
    int n;
    enable_cfg(24'h1, 5'd1, 20'h0);
    n = cyc;
    exp_q.push_back(n + 3);
    repeat (10) begin
      bus.trig_i = 24'h1;
      tick(2);
      bus.trig_i = '0;
      tick(2);
    end
    tick(30);
    checks++; if (bus.trig_count_o !== 16'd1) begin errors++; $display("FAIL holdoff_count: got %0d required 1", bus.trig_count_o); end
    n = cyc;
    exp_q.push_back(n + 3);
    pulse(24'h1);
    tick(30);
    checks++; if (bus.trig_count_o !== 16'd2) begin errors++; $display("FAIL rearm_count: got %0d required 2", bus.trig_count_o); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL holdoff_missed: %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_config_gating;
    int n;
    enable_cfg(24'h3, 5'd2, 20'h0);
    bus.thresh_i = 5'd1;
    tick(2);
    pulse(24'h1);
    tick(20);
    checks++; if (bus.trig_count_o !== 16'd0) begin errors++; $display("FAIL gating_count: got %0d required 0", bus.trig_count_o); end
    bus.en_i = 1'b0;
    tick(1);
    bus.en_i = 1'b1;
    tick(1);
    n = cyc;
    exp_q.push_back(n + 3);
    pulse(24'h1);
    tick(25);
    checks++; if (bus.trig_count_o !== 16'd1) begin errors++; $display("FAIL regated_count: got %0d required 1", bus.trig_count_o); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gating_missed: %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_thresh_zero;
    int n;
    enable_cfg(24'hFFFFFF, 5'd0, 20'h08421);
    n = cyc;
    pulse(24'hFFFFFF);
    tick(11);
    checks++; if (bus.active_cnt_o !== 5'd24) begin errors++; $display("FAIL win11_last: active_cnt %0d at n+12 required 24", bus.active_cnt_o); end
    tick(1);
    checks++; if (bus.active_cnt_o !== 5'd0) begin errors++; $display("FAIL win11_end: active_cnt %0d at n+13 required 0", bus.active_cnt_o); end
    tick(10);
    checks++; if (bus.trig_count_o !== 16'd0) begin errors++; $display("FAIL thresh0_count: got %0d required 0", bus.trig_count_o); end
  endtask

  task automatic test_saturation;
    int n;
    enable_cfg(24'h1, 5'd1, 20'h0);
    force dut.trig_count_q = 16'hFFFE;
    #2;
    release dut.trig_count_q;
    tick(1);
    for (int k = 0; k < 2; k++) begin
      n = cyc;
      exp_q.push_back(n + 3);
      pulse(24'h1);
      tick(30);
      checks++; if (bus.trig_count_o !== 16'hFFFF) begin errors++; $display("FAIL saturate_%0d: got %h required ffff", k, bus.trig_count_o); end
    end
  endtask

  task automatic test_reset_in_hold;
    int n;
    enable_cfg(24'h3, 5'd1, 20'h0);
    n = cyc;
    exp_q.push_back(n + 3);
    pulse(24'h1);
    tick(4);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.trig_o !== 1'b0) begin errors++; $display("FAIL async_trig: got %0b required 0", bus.trig_o); end
    checks++; if (bus.active_cnt_o !== 5'd0) begin errors++; $display("FAIL async_active: got %0d required 0", bus.active_cnt_o); end
    checks++; if (bus.trig_count_o !== 16'd0) begin errors++; $display("FAIL async_count: got %0d required 0", bus.trig_count_o); end
    bus.en_i = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    pulse(24'h1);
    tick(20);
    checks++; if (bus.trig_count_o !== 16'd0) begin errors++; $display("FAIL dis_after_reset: got %0d required 0", bus.trig_count_o); end
    bus.en_i = 1'b1;
    tick(1);
    n = cyc;
    exp_q.push_back(n + 3);
    pulse(24'h1);
    tick(25);
    checks++; if (bus.trig_count_o !== 16'd1) begin errors++; $display("FAIL reenable_count: got %0d required 1", bus.trig_count_o); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_missed: %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_window_latency();
    test_mask();
    test_holdoff();
    test_config_gating();
    test_thresh_zero();
    test_saturation();
    test_reset_in_hold();
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
